// File: rtl/xb_msg_fifo.sv
// rtl/xb_msg_fifo.sv - single-clock message FIFO with registered read port and registered flags
// Optional occupancy output data_count exists only when XB_FIFO_COUNT_EN is defined.
module xb_msg_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int DELAY = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             overflow,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
`ifdef XB_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] data_count
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, wptr_nxt, rptr_nxt;
  logic             wr_ok, rd_ok;

  // DELAY only matters to simulation models with delayed outputs; here outputs change at the edge.
  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || DELAY < 0) begin : g_bad_cfg
      $error("xb_msg_fifo: DEPTH must be a power of two >= 4 and DELAY non-negative");
    end
  endgenerate

  always_comb begin
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wptr_nxt = wptr + {{AW{1'b0}}, wr_ok};
    rptr_nxt = rptr + {{AW{1'b0}}, rd_ok};
  end

  // Storage has no reset so it can map onto block or distributed RAM.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr     <= '0;
      rptr     <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      dout     <= '0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      empty    <= (wptr_nxt == rptr_nxt);
      full     <= (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
      overflow <= wr_en && full;
      if (rd_ok) dout <= mem[rptr[AW-1:0]];
    end
  end

`ifdef XB_FIFO_COUNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) data_count <= '0;
    else        data_count <= wptr_nxt - rptr_nxt;
  end
`endif

endmodule

// File: tb/tb_xb_msg_fifo.sv
// tb/tb_xb_msg_fifo.sv - directed and random checks of xb_msg_fifo against a queue model (DEPTH=4)
// Also checks data_count when XB_FIFO_COUNT_EN is defined.
module tb_xb_msg_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             full, overflow, empty;
  logic [WIDTH-1:0] dout;
`ifdef XB_FIFO_COUNT_EN
  logic [AW:0]      data_count;
`endif

  xb_msg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY(1)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .din(din),
    .wr_en(wr_en),
    .full(full),
    .overflow(overflow),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty)
`ifdef XB_FIFO_COUNT_EN
    ,
    .data_count(data_count)
`endif
  );

  always #5 CLK = ~CLK;

  int               errors = 0;
  int               checks = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  logic             exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, dout, exp_dout);
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
`ifdef XB_FIFO_COUNT_EN
    check({tag, ".count"}, 32'(data_count), 32'(q.size()));
`endif
  endtask

  // One clock: drive, let the edge happen, update the model from pre-edge occupancy, check.
  task automatic step(input string tag, input logic w, input logic [31:0] d, input logic r);
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge CLK);
    if (r && !was_empty) exp_dout = q.pop_front();
    if (w && !was_full) q.push_back(d);
    exp_ovf = w && was_full;
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  // Asserts reset between edges, checks immediately, holds for some cycles, releases mid-cycle.
  task automatic do_reset(input string tag, input int cycles);
    wr_en = 1'b0;
    rd_en = 1'b0;
    RESET = 1'b0;
    #1;
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    check_all({tag, ".async"});
    repeat (cycles) begin
      @(posedge CLK);
      #1;
      check_all({tag, ".hold"});
    end
    RESET = 1'b1;
  endtask

  initial begin
    #2;
    do_reset("reset", 3);
    step("idle0", 1'b0, 32'h0, 1'b0);
    step("idle1", 1'b0, 32'h0, 1'b0);

    for (int i = 1; i <= 4; i++) step("order_wr", 1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) step("order_rd", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 5; i++) step("fill_wr", 1'b1, 32'hA0 + 32'(i), 1'b0);
    step("fill_ovf_drop", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step("fill_rd", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 4; i++) step("simfull_wr", 1'b1, 32'hC0 + 32'(i), 1'b0);
    step("simfull_both", 1'b1, 32'hBB, 1'b1);
    step("simfull_both2", 1'b1, 32'hBC, 1'b1);
    for (int i = 0; i < 4; i++) step("simfull_drain", 1'b0, 32'h0, 1'b1);

    step("uflow_wr", 1'b1, 32'h1234_5678, 1'b0);
    step("uflow_rd", 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step("uflow_empty_rd", 1'b0, 32'h0, 1'b1);
    step("empty_both", 1'b1, 32'h0000_0077, 1'b1);
    step("empty_both_rd", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 10; i++) step("wrap", 1'b1, 32'h100 + 32'(i), i >= 2);
    for (int i = 0; i < 4; i++) step("wrap_drain", 1'b0, 32'h0, 1'b1);

    step("midrst_wr", 1'b1, 32'h11, 1'b0);
    step("midrst_wr", 1'b1, 32'h22, 1'b0);
    do_reset("midrst", 2);
    step("midrst_post_wr", 1'b1, 32'h55, 1'b0);
    step("midrst_post_rd", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 400; i++)
      step("random", $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50);
    for (int i = 0; i < 5; i++) step("random_drain", 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
